mac_operand_feeder: RTL and testbench
=====================================

// Module: mac_operand_feeder
// PURPOSE
//  Upstream stage of the MAC: streams one dot product (A row x B column) from
//  two synchronous read memories into the MAC operand/enable inputs.
//  Captures the final 64-bit accumulation and reports it with a done pulse.
//  Sits between the matrix controller (start/len/base addresses) and the MAC.
//  MAC contract relied upon: en=0 at a clk edge clears the accumulator;
//  en=1 accumulates ain*bin; dout is registered (updates on that same edge).
// PARAMETERS
//  DATA_W  32  operand width (ain/bin)
//  ACC_W   64  MAC result width (dout)
//  ADDR_W  10  memory address width; addresses wrap modulo 2**ADDR_W
//  LEN_W   8   width of len; max vector length 2**LEN_W-1
// PORTS
//  clk         in   1       single clock, rising edge
//  rst         in   1       asynchronous, active-high reset
//  start       in   1       request a dot product; sampled only in IDLE
//  len         in   LEN_W   number of element pairs, latched on start
//  a_base      in   ADDR_W  first A address
//  b_base      in   ADDR_W  first B address
//  b_stride    in   ADDR_W  B address increment per element (column walk)
//  a_rd_en     out  1       A memory read enable
//  a_addr      out  ADDR_W  A read address
//  a_rdata     in   DATA_W  A data, valid exactly 1 cycle after a_rd_en
//  b_rd_en     out  1       B memory read enable
//  b_addr      out  ADDR_W  B read address
//  b_rdata     in   DATA_W  B data, valid exactly 1 cycle after b_rd_en
//  mac_ain     out  DATA_W  to MAC ain (registered)
//  mac_bin     out  DATA_W  to MAC bin (registered)
//  mac_en      out  1       to MAC en (registered)
//  mac_dout    in   ACC_W   from MAC dout
//  busy        out  1       high from cycle after accepted start until done
//  done        out  1       one-cycle pulse; result valid in that cycle
//  result      out  ACC_W   captured dot product, held until next done
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE; async assert, sync deassert assumed.
//  FSM: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
//  Start accepted at edge E0 (IDLE, start=1). len, bases, stride latched.
//  ISSUE: cycles 1..len after E0; a_rd_en=b_rd_en=1; element k (0-based)
//   a_addr=a_base+k, b_addr=b_base+k*b_stride, both mod 2**ADDR_W.
//  Data pipe: issue cycle c -> rdata cycle c+1 -> mac_ain/bin/en=1 cycle c+2.
//  mac_en=0 in cycles 1 and 2 -> MAC cleared before first accumulate.
//  DRAIN: cycles len+1..len+3; mac_en falls after last element (cycle len+3).
//  result <= mac_dout at end of cycle len+3; done=1, busy=0 in cycle len+4.
//  Total: done exactly len+4 cycles after E0. Back-to-back start accepted in
//   the cycle after done (IDLE).
//  len=0: no reads, mac_en stays 0; done in cycle 1 with result=0.
//  start while busy: ignored, no effect on latched params.
//  Operand bits passed unmodified (no sign handling; MAC defines signedness).
//  rst mid-operation: immediate return to IDLE, rd_en/mac_en=0, no done,
//   result cleared to 0.
// STRUCTURE
//  Shared include mm_defs.vh: DATA_W/ACC_W/ADDR_W defaults, FSM state
//   localparams (IDLE/ISSUE/DRAIN/DONE), MAC clear-on-en-low contract note.
//  One sub-module: feeder_addr_gen (element counter, A incrementer, B stride
//   accumulator, wrap); FSM, data pipe and result capture in top.
// TESTING
//  len=4, a_base=0, b_base=0, stride=1, A[i]=i, B[i]=i+1 -> result=20,
//   done 8 cycles after start edge; mac_en high for exactly 4 cycles.
//  len=3, b_base=2, stride=4 -> b_addr sequence 2,6,10; a_addr 0,1,2.
//  A=B=32'hFFFFFFFF, len=1 -> result=64'hFFFFFFFE00000001.
//  a_base=2**ADDR_W-2, len=4 -> a_addr 1022,1023,0,1 (wrap, ADDR_W=10).
//  len=0 -> done cycle 1, result=0, no rd_en; start pulsed while busy -> ignored.
//  rst asserted mid-ISSUE -> outputs 0 immediately, no done; next start runs
//   clean (MAC cleared, correct result).

Source files
------------

// File: rtl/mac_operand_feeder_pkg.sv
// Shared definitions for the MAC operand feeder: default widths and FSM states.
// MAC contract assumed by this block: en=0 at a clock edge clears the MAC
// accumulator, en=1 accumulates ain*bin, and dout updates on that same edge.
package mac_operand_feeder_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ACC_W  = 64;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_LEN_W  = 8;

    // Cycles spent in DRAIN: two for the memory/operand pipe, one for MAC dout.
    localparam int DRAIN_CYCLES = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/feeder_addr_gen.sv
// Address generator for the feeder: walks A row-wise (+1) and B column-wise
// (+stride), both wrapping modulo 2**ADDR_W, and counts remaining elements.
module feeder_addr_gen
    import mac_operand_feeder_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] a_base,
    input  logic [ADDR_W-1:0] b_base,
    input  logic [ADDR_W-1:0] b_stride,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    output logic              last
);

    logic [ADDR_W-1:0] stride_q;
    logic [LEN_W-1:0]  remaining;

    // Latch the walk parameters on load, then advance one element per step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_addr    <= '0;
            b_addr    <= '0;
            stride_q  <= '0;
            remaining <= '0;
        end else if (load) begin
            a_addr    <= a_base;
            b_addr    <= b_base;
            stride_q  <= b_stride;
            remaining <= len;
        end else if (step) begin
            a_addr    <= a_addr + ADDR_W'(1);
            b_addr    <= b_addr + stride_q;
            remaining <= remaining - LEN_W'(1);
        end
    end

    assign last = (remaining == LEN_W'(1));

endmodule

// File: rtl/mac_operand_feeder.sv
// Streams one dot product (A row x B column) from two synchronous-read
// memories into the MAC, then captures the final accumulation with a done pulse.
module mac_operand_feeder
    import mac_operand_feeder_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] a_base,
    input  logic [ADDR_W-1:0] b_base,
    input  logic [ADDR_W-1:0] b_stride,
    output logic              a_rd_en,
    output logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_rdata,
    output logic              b_rd_en,
    output logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_rdata,
    output logic [DATA_W-1:0] mac_ain,
    output logic [DATA_W-1:0] mac_bin,
    output logic              mac_en,
    input  logic [ACC_W-1:0]  mac_dout,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  result
);

    localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

    state_t     state, next_state;
    logic       accept;
    logic       issuing;
    logic       last;
    logic       rdata_vld;
    logic [1:0] drain_cnt;

    assign accept  = (state == IDLE) && start;
    assign issuing = (state == ISSUE);

    feeder_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .step     (issuing),
        .len      (len),
        .a_base   (a_base),
        .b_base   (b_base),
        .b_stride (b_stride),
        .a_addr   (a_addr),
        .b_addr   (b_addr),
        .last     (last)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state and decoded control outputs; len=0 skips straight to DONE.
    always_comb begin
        next_state = state;
        a_rd_en    = 1'b0;
        b_rd_en    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = (len == '0) ? DONE : ISSUE;
            end
            ISSUE: begin
                a_rd_en = 1'b1;
                b_rd_en = 1'b1;
                busy    = 1'b1;
                if (last) next_state = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_cnt == DRAIN_LAST) next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Counts cycles spent in DRAIN so the result is taken once MAC dout settles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 drain_cnt <= '0;
        else if (state != DRAIN) drain_cnt <= '0;
        else                     drain_cnt <= drain_cnt + 2'd1;
    end

    // Operand pipe: read issued in cycle c, data in c+1, MAC operands in c+2.
    // mac_en low outside that window keeps the MAC cleared between products.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_vld <= 1'b0;
            mac_en    <= 1'b0;
            mac_ain   <= '0;
            mac_bin   <= '0;
        end else begin
            rdata_vld <= issuing;
            mac_en    <= rdata_vld;
            if (rdata_vld) begin
                mac_ain <= a_rdata;
                mac_bin <= b_rdata;
            end
        end
    end

    // Result capture: MAC dout at the end of the last DRAIN cycle, or 0 for len=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                         result <= '0;
        else if (accept && (len == '0))                  result <= '0;
        else if ((state == DRAIN) && (drain_cnt == DRAIN_LAST)) result <= mac_dout;
    end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Directed testbench for mac_operand_feeder with behavioural memories and MAC.
module tb_mac_operand_feeder;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic [9:0]  a_base;
    logic [9:0]  b_base;
    logic [9:0]  b_stride;
    logic        a_rd_en;
    logic [9:0]  a_addr;
    logic [31:0] a_rdata;
    logic        b_rd_en;
    logic [9:0]  b_addr;
    logic [31:0] b_rdata;
    logic [31:0] mac_ain;
    logic [31:0] mac_bin;
    logic        mac_en;
    logic [63:0] mac_dout;
    logic        busy;
    logic        done;
    logic [63:0] result;

    logic [31:0] aMem [1024];
    logic [31:0] bMem [1024];

    int checkCount;
    int failCount;

    logic [9:0] aQ[$];
    logic [9:0] bQ[$];
    int          doneCycle;
    int          macEnCount;
    logic        busyAtStart;
    logic        busyAtDone;
    logic [63:0] capturedResult;
    int          doneSeen;

    mac_operand_feeder dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .a_base   (a_base),
        .b_base   (b_base),
        .b_stride (b_stride),
        .a_rd_en  (a_rd_en),
        .a_addr   (a_addr),
        .a_rdata  (a_rdata),
        .b_rd_en  (b_rd_en),
        .b_addr   (b_addr),
        .b_rdata  (b_rdata),
        .mac_ain  (mac_ain),
        .mac_bin  (mac_bin),
        .mac_en   (mac_en),
        .mac_dout (mac_dout),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memories: data appears one cycle after the read enable.
    always @(posedge clk) begin
        if (a_rd_en) a_rdata <= aMem[a_addr];
        if (b_rd_en) b_rdata <= bMem[b_addr];
    end

    // MAC model: en low clears, en high accumulates an unsigned product.
    always @(posedge clk) begin
        if (!mac_en) mac_dout <= 64'd0;
        else         mac_dout <= mac_dout + (64'(mac_ain) * 64'(mac_bin));
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Runs one product; optionally pulses start with other params at cycle pulseAt.
    task automatic applyStimulus(input int l, input int ab, input int bb, input int st, input int pulseAt);
        @(negedge clk);
        len      = 8'(l);
        a_base   = 10'(ab);
        b_base   = 10'(bb);
        b_stride = 10'(st);
        start    = 1'b1;
        @(posedge clk);
        doneCycle   = 0;
        macEnCount  = 0;
        busyAtStart = 1'b0;
        busyAtDone  = 1'b1;
        capturedResult = '1;
        aQ.delete();
        bQ.delete();
        for (int n = 1; n <= 300 && doneCycle == 0; n++) begin
            @(negedge clk);
            if (n == 1) busyAtStart = busy;
            if (a_rd_en) aQ.push_back(a_addr);
            if (b_rd_en) bQ.push_back(b_addr);
            if (mac_en) macEnCount++;
            if (done) begin
                doneCycle      = n;
                capturedResult = result;
                busyAtDone     = busy;
            end
            if (n == pulseAt) begin
                start    = 1'b1;
                len      = 8'd3;
                a_base   = 10'd500;
                b_base   = 10'd600;
                b_stride = 10'd7;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        for (int i = 0; i < 1024; i++) begin
            aMem[i] = 32'(i);
            bMem[i] = 32'(i + 1);
        end
        aMem[100] = 32'hFFFF_FFFF;
        bMem[200] = 32'hFFFF_FFFF;

        rst = 1'b1; start = 1'b0; len = '0; a_base = '0; b_base = '0; b_stride = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy",   64'(busy),    64'd0);
        checkOutput("reset_done",   64'(done),    64'd0);
        checkOutput("reset_rd_en",  64'(a_rd_en), 64'd0);
        checkOutput("reset_mac_en", 64'(mac_en),  64'd0);
        checkOutput("reset_result", result,       64'd0);
        rst = 1'b0;

        $display("[TB] basic dot product len=4");
        applyStimulus(4, 0, 0, 1, 0);
        checkOutput("t1_result",     capturedResult,     64'd20);
        checkOutput("t1_done_cycle", 64'(doneCycle),     64'd8);
        checkOutput("t1_mac_en_cnt", 64'(macEnCount),    64'd4);
        checkOutput("t1_busy_start", 64'(busyAtStart),   64'd1);
        checkOutput("t1_busy_done",  64'(busyAtDone),    64'd0);

        $display("[TB] strided B walk len=3");
        applyStimulus(3, 0, 2, 4, 0);
        checkOutput("t2_a_cnt", 64'(aQ.size()), 64'd3);
        checkOutput("t2_b_cnt", 64'(bQ.size()), 64'd3);
        checkOutput("t2_a0", 64'(aQ[0]), 64'd0);
        checkOutput("t2_a1", 64'(aQ[1]), 64'd1);
        checkOutput("t2_a2", 64'(aQ[2]), 64'd2);
        checkOutput("t2_b0", 64'(bQ[0]), 64'd2);
        checkOutput("t2_b1", 64'(bQ[1]), 64'd6);
        checkOutput("t2_b2", 64'(bQ[2]), 64'd10);
        checkOutput("t2_result", capturedResult, 64'd29);
        checkOutput("t2_done_cycle", 64'(doneCycle), 64'd7);

        $display("[TB] full-scale operands len=1");
        applyStimulus(1, 100, 200, 1, 0);
        checkOutput("t3_result", capturedResult, 64'hFFFF_FFFE_0000_0001);
        checkOutput("t3_done_cycle", 64'(doneCycle), 64'd5);

        $display("[TB] A address wrap len=4");
        applyStimulus(4, 1022, 0, 1, 0);
        checkOutput("t4_a0", 64'(aQ[0]), 64'd1022);
        checkOutput("t4_a1", 64'(aQ[1]), 64'd1023);
        checkOutput("t4_a2", 64'(aQ[2]), 64'd0);
        checkOutput("t4_a3", 64'(aQ[3]), 64'd1);
        checkOutput("t4_result", capturedResult, 64'd3072);

        $display("[TB] zero-length product");
        applyStimulus(0, 5, 5, 1, 0);
        checkOutput("t5_done_cycle", 64'(doneCycle), 64'd1);
        checkOutput("t5_result",     capturedResult, 64'd0);
        checkOutput("t5_rd_cnt",     64'(aQ.size()), 64'd0);
        checkOutput("t5_mac_en_cnt", 64'(macEnCount), 64'd0);

        $display("[TB] start while busy is ignored");
        applyStimulus(4, 0, 0, 1, 3);
        checkOutput("t6_result",     capturedResult,  64'd20);
        checkOutput("t6_done_cycle", 64'(doneCycle),  64'd8);
        checkOutput("t6_a3",         64'(aQ[3]),      64'd3);

        $display("[TB] reset mid-operation");
        @(negedge clk);
        len = 8'd4; a_base = '0; b_base = '0; b_stride = 10'd1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_pre_mac_en", 64'(mac_en), 64'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst_a_rd_en", 64'(a_rd_en), 64'd0);
        checkOutput("rst_b_rd_en", 64'(b_rd_en), 64'd0);
        checkOutput("rst_mac_en",  64'(mac_en),  64'd0);
        checkOutput("rst_busy",    64'(busy),    64'd0);
        checkOutput("rst_result",  result,       64'd20 - 64'd20);
        @(negedge clk);
        rst = 1'b0;
        doneSeen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        checkOutput("rst_no_done", 64'(doneSeen), 64'd0);

        applyStimulus(4, 0, 0, 1, 0);
        checkOutput("t7_result",     capturedResult, 64'd20);
        checkOutput("t7_done_cycle", 64'(doneCycle), 64'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
